// File: rtl/panel_input_ctrl.sv
// Push-button front end: synchronizes and debounces btn_next/btn_speed and
// turns them into the pattern mode (short step / long-press return) and speed select.
module panel_input_ctrl #(
   parameter int DB_COUNT   = 500000,
   parameter int LONG_COUNT = 50000000,
   parameter int CNT_W      = 26
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_next,
   input  logic       btn_speed,
   output logic [1:0] mode,
   output logic       freq,
   output logic       press_next,
   output logic       press_speed,
   output logic       long_press
);

   generate
      if (CNT_W < $clog2(LONG_COUNT + 1) || CNT_W < $clog2(DB_COUNT + 1)) begin : g_cnt_w_check
         $error("panel_input_ctrl: CNT_W too small for LONG_COUNT/DB_COUNT");
      end
   endgenerate

   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_COUNT - 1);
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_COUNT - 1);
   localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_COUNT);

   typedef enum logic [1:0] {M0, M1, M2, M3} state_t;

   // Channel 0 = next, channel 1 = speed.
   logic [1:0]       btn_raw;
   logic [1:0]       s1_reg;
   logic [1:0]       s2_reg;
   logic [1:0]       db_reg;
   logic [1:0]       db_d_reg;
   logic [1:0]       press_reg;
   logic [1:0]       rise;
   logic [CNT_W-1:0] dc_reg [2];

   logic [CNT_W-1:0] hc_reg;
   logic             long_reg;
   logic             long_evt;
   logic             freq_reg;
   state_t           state_reg;
   state_t           state_next;

   assign btn_raw = {btn_speed, btn_next};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_chan
         assign rise[gi] = db_reg[gi] & ~db_d_reg[gi];

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               s1_reg[gi]    <= 1'b0;
               s2_reg[gi]    <= 1'b0;
               db_reg[gi]    <= 1'b0;
               db_d_reg[gi]  <= 1'b0;
               press_reg[gi] <= 1'b0;
               dc_reg[gi]    <= '0;
            end else begin
               s1_reg[gi]    <= btn_raw[gi];
               s2_reg[gi]    <= s1_reg[gi];
               db_d_reg[gi]  <= db_reg[gi];
               press_reg[gi] <= rise[gi];
               // Any return to the current level restarts the stability count.
               if (s2_reg[gi] == db_reg[gi]) begin
                  dc_reg[gi] <= '0;
               end else if (dc_reg[gi] == DB_LAST) begin
                  db_reg[gi] <= s2_reg[gi];
                  dc_reg[gi] <= '0;
               end else begin
                  dc_reg[gi] <= dc_reg[gi] + 1'b1;
               end
            end
         end
      end
   endgenerate

   // Hold counter saturates at LONG_COUNT so a single hold yields one long pulse.
   assign long_evt = db_reg[0] && (hc_reg == LONG_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hc_reg    <= '0;
         long_reg  <= 1'b0;
         freq_reg  <= 1'b0;
         state_reg <= M0;
      end else begin
         if (!db_reg[0]) begin
            hc_reg <= '0;
         end else if (hc_reg != LONG_MAX) begin
            hc_reg <= hc_reg + 1'b1;
         end
         long_reg  <= long_evt;
         state_reg <= state_next;
         if (rise[1]) begin
            freq_reg <= ~freq_reg;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      if (long_evt) begin
         state_next = M0;
      end else if (rise[0]) begin
         case (state_reg)
            M0:      state_next = M1;
            M1:      state_next = M2;
            M2:      state_next = M3;
            default: state_next = M0;
         endcase
      end
   end

   assign mode        = state_reg;
   assign freq        = freq_reg;
   assign press_next  = press_reg[0];
   assign press_speed = press_reg[1];
   assign long_press  = long_reg;

endmodule

// File: tb/tb_panel_input_ctrl.sv
// Directed bench for panel_input_ctrl with short counts (DB_COUNT=4, LONG_COUNT=20).
module tb_panel_input_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       btn_next;
   logic       btn_speed;
   logic [1:0] mode;
   logic       freq;
   logic       press_next;
   logic       press_speed;
   logic       long_press;

   int n_cmp = 0;
   int n_bad = 0;
   int np = 0;
   int sp = 0;
   int lp = 0;
   int base_np;
   int base_lp;

   panel_input_ctrl #(.DB_COUNT(4), .LONG_COUNT(20), .CNT_W(6)) dut (
      .clk(clk),
      .reset(reset),
      .btn_next(btn_next),
      .btn_speed(btn_speed),
      .mode(mode),
      .freq(freq),
      .press_next(press_next),
      .press_speed(press_speed),
      .long_press(long_press)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!reset) begin
         if (press_next === 1'b1) np++;
         if (press_speed === 1'b1) sp++;
         if (long_press === 1'b1) lp++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   // Clean press: raw level held 10 sampled edges, pulse lands 7 steps after the change.
   task automatic press_clean(input string tag, input logic [1:0] exp_mode);
      btn_next = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         step();
         check(tag, press_next, (i == 7));
      end
      check(tag, mode, exp_mode);
      btn_next = 1'b0;
      for (int i = 0; i < 10; i++) step();
      $display("press %s: mode=%0d", tag, mode);
   endtask

   initial begin
      reset = 1'b1;
      btn_next = 1'b0;
      btn_speed = 1'b0;
      for (int i = 0; i < 3; i++) step();
      check("rst_mode", mode, 0);
      check("rst_freq", freq, 0);
      check("rst_pn", press_next, 0);
      check("rst_ps", press_speed, 0);
      check("rst_lp", long_press, 0);
      reset = 1'b0;
      step();

      // Clean press: nothing early, pulse and mode step together, no release pulse.
      base_np = np;
      btn_next = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         step();
         check("clean_pulse", press_next, (i == 7));
         check("clean_mode", mode, (i >= 7) ? 1 : 0);
      end
      step(); step();
      btn_next = 1'b0;
      for (int i = 0; i < 12; i++) step();
      check("clean_count", np - base_np, 1);
      check("clean_mode_end", mode, 1);
      $display("clean press: mode=%0d pulses=%0d", mode, np - base_np);

      // Bounce then stable high.
      base_np = np;
      for (int i = 0; i < 4; i++) begin
         btn_next = ~i[0];
         step();
      end
      btn_next = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         step();
         check("bounce_pulse", press_next, (i == 7));
      end
      check("bounce_mode", mode, 2);
      btn_next = 1'b0;
      for (int i = 0; i < 10; i++) step();
      check("bounce_count", np - base_np, 1);

      // Three-cycle glitch is shorter than the debounce window.
      btn_next = 1'b1;
      step(); step(); step();
      btn_next = 1'b0;
      for (int i = 0; i < 12; i++) step();
      check("glitch_count", np - base_np, 1);
      check("glitch_mode", mode, 2);
      $display("bounce/glitch: mode=%0d pulses=%0d", mode, np - base_np);

      // Wrap through all four modes.
      do_reset();
      base_np = np;
      press_clean("wrap1", 1);
      press_clean("wrap2", 2);
      press_clean("wrap3", 3);
      press_clean("wrap0", 0);
      check("wrap_count", np - base_np, 4);

      // Long press from mode 2.
      do_reset();
      press_clean("lp_pre1", 1);
      press_clean("lp_pre2", 2);
      base_lp = lp;
      btn_next = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         step();
         check("long_pulse", long_press, (i == 26));
         if (i == 7)  check("long_step", mode, 3);
         if (i == 25) check("long_before", mode, 3);
         if (i == 26) check("long_zero", mode, 0);
      end
      check("long_count", lp - base_lp, 1);
      check("long_mode_end", mode, 0);
      btn_next = 1'b0;
      for (int i = 0; i < 10; i++) step();
      $display("long press: mode=%0d long_pulses=%0d", mode, lp - base_lp);

      // Both buttons pressed together.
      btn_next = 1'b1;
      btn_speed = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         step();
         check("both_pn", press_next, (i == 7));
         check("both_ps", press_speed, (i == 7));
         check("both_freq", freq, (i >= 7) ? 1 : 0);
         check("both_mode", mode, (i >= 7) ? 1 : 0);
      end
      btn_speed = 1'b0;
      for (int i = 0; i < 10; i++) step();
      check("both_mode_end", mode, 1);
      $display("concurrent press: mode=%0d freq=%0d", mode, freq);

      // Asynchronous reset mid-cycle with buttons high and mode/freq non-zero.
      btn_speed = 1'b1;
      #3;
      reset = 1'b1;
      #1;
      check("async_mode", mode, 0);
      check("async_freq", freq, 0);
      check("async_pn", press_next, 0);
      check("async_ps", press_speed, 0);
      btn_speed = 1'b0;
      btn_next = 1'b0;
      step();
      reset = 1'b0;
      for (int i = 0; i < 10; i++) step();

      // Reset lands mid-debounce: interrupted press emits nothing.
      base_np = np;
      btn_next = 1'b1;
      for (int i = 0; i < 4; i++) step();
      reset = 1'b1;
      btn_next = 1'b0;
      step(); step();
      reset = 1'b0;
      for (int i = 0; i < 12; i++) step();
      check("mid_db_count", np - base_np, 0);
      check("mid_db_mode", mode, 0);

      // A fresh press afterwards shows the full debounce window again.
      press_clean("after_rst", 1);

      // Button held through reset release registers one press.
      base_np = np;
      btn_next = 1'b1;
      reset = 1'b1;
      step(); step();
      reset = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         step();
         check("held_pulse", press_next, (i == 7));
      end
      check("held_mode", mode, 1);
      btn_next = 1'b0;
      for (int i = 0; i < 10; i++) step();
      check("held_count", np - base_np, 1);
      $display("held through reset: mode=%0d", mode);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
